// File: rtl/mipi_tx_frame_sched.sv
// MIPI TX frame scheduler: arbitrates payload/confirmation requests and sequences
// PHY reset release, pattern-generator enable, frame counting and the inter-grant gap.
module mipi_tx_frame_sched #(
    parameter int unsigned RST_WAIT = 16,
    parameter int unsigned FRAMES   = 1,
    parameter int unsigned GAP      = 8
) (
    input  logic       tx_pixel_clk,
    input  logic       rst_n,
    input  logic       payload_req,
    input  logic       confirm_req,
    input  logic       vsync_in,
    output logic       phy_rstn,
    output logic       gen_en,
    output logic       sel_confirm,
    output logic       busy,
    output logic       done,
    output logic [7:0] drop_cnt,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_SEND = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] L_WAIT_LAST  = 8'(RST_WAIT - 1);
    localparam logic [7:0] L_GAP_LAST   = 8'(GAP - 1);
    localparam logic [3:0] L_FRAME_LAST = 4'(FRAMES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pend_pay;
    logic        r_pend_cfm;
    logic        r_rr_cfm;
    logic        r_sel;
    logic        r_vs_prev;
    logic [7:0]  r_cyc;
    logic [3:0]  r_frm;

    logic        w_grant;
    logic        w_grant_cfm;
    logic        w_done;
    logic        w_vs_fall;
    logic        w_clr_pay;
    logic        w_clr_cfm;
    logic        w_drop_pay;
    logic        w_drop_cfm;
    logic [8:0]  w_drop_sum;

    assign w_vs_fall = r_vs_prev & ~vsync_in;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_cfm = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_pay | r_pend_cfm) begin
                    w_grant     = 1'b1;
                    w_grant_cfm = r_pend_cfm & (~r_pend_pay | r_rr_cfm);
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (r_cyc == L_WAIT_LAST) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_vs_fall && (r_frm == L_FRAME_LAST)) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cyc == L_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Requests are one-cycle pulses with no back-pressure: a pulse either sets its
    // pending bit or, if that bit is already set and not being granted, is dropped.
    assign w_clr_pay  = w_grant & ~w_grant_cfm;
    assign w_clr_cfm  = w_grant &  w_grant_cfm;
    assign w_drop_pay = payload_req & r_pend_pay & ~w_clr_pay;
    assign w_drop_cfm = confirm_req & r_pend_cfm & ~w_clr_cfm;
    assign w_drop_sum = {1'b0, drop_cnt} + {8'd0, w_drop_pay} + {8'd0, w_drop_cfm};

    always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend_pay <= 1'b0;
            r_pend_cfm <= 1'b0;
            r_rr_cfm   <= 1'b1;
            r_sel      <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_cyc      <= 8'd0;
            r_frm      <= 4'd0;
            drop_cnt   <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs_prev  <= vsync_in;
            r_pend_pay <= (r_pend_pay & ~w_clr_pay) | payload_req;
            r_pend_cfm <= (r_pend_cfm & ~w_clr_cfm) | confirm_req;
            drop_cnt   <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_grant) begin
                r_sel    <= w_grant_cfm;
                r_rr_cfm <= ~w_grant_cfm;
            end
            if (w_state_nxt != r_state) begin
                r_cyc <= 8'd0;
                r_frm <= 4'd0;
            end else if (r_state == ST_WAKE || r_state == ST_HOLD) begin
                r_cyc <= r_cyc + 8'd1;
            end else if (r_state == ST_SEND && w_vs_fall) begin
                r_frm <= r_frm + 4'd1;
            end
        end
    end

    // The PHY is released in the grant cycle itself so WAKE sees it high from cycle one.
    assign phy_rstn    = (r_state != ST_IDLE) | w_grant;
    assign gen_en      = (r_state == ST_SEND);
    assign busy        = (r_state != ST_IDLE);
    assign done        = w_done;
    assign sel_confirm = r_sel;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mipi_tx_frame_sched.sv
// Directed bench for mipi_tx_frame_sched: default instance (16/1/8) plus a
// short three-frame instance (4/3/4) for frame counting and vsync masking.
module tb_mipi_tx_frame_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       payload_req, confirm_req, vsync_in;
    logic       phy_rstn, gen_en, sel_confirm, busy, done;
    logic [7:0] drop_cnt;
    logic [1:0] dbg_state;

    logic       payload_req_3, confirm_req_3, vsync_in_3;
    logic       phy_rstn_3, gen_en_3, sel_confirm_3, busy_3, done_3;
    logic [7:0] drop_cnt_3;
    logic [1:0] dbg_state_3;

    int n_cmp = 0;
    int n_err = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    mipi_tx_frame_sched #(.RST_WAIT(16), .FRAMES(1), .GAP(8)) dut (
        .tx_pixel_clk(clk), .rst_n(rst_n), .payload_req(payload_req),
        .confirm_req(confirm_req), .vsync_in(vsync_in), .phy_rstn(phy_rstn),
        .gen_en(gen_en), .sel_confirm(sel_confirm), .busy(busy), .done(done),
        .drop_cnt(drop_cnt), .o_dbg_state(dbg_state)
    );

    mipi_tx_frame_sched #(.RST_WAIT(4), .FRAMES(3), .GAP(4)) dut3 (
        .tx_pixel_clk(clk), .rst_n(rst_n), .payload_req(payload_req_3),
        .confirm_req(confirm_req_3), .vsync_in(vsync_in_3), .phy_rstn(phy_rstn_3),
        .gen_en(gen_en_3), .sel_confirm(sel_confirm_3), .busy(busy_3), .done(done_3),
        .drop_cnt(drop_cnt_3), .o_dbg_state(dbg_state_3)
    );

    always @(posedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        payload_req = 1'b0; confirm_req = 1'b0; vsync_in = 1'b1;
        payload_req_3 = 1'b0; confirm_req_3 = 1'b0; vsync_in_3 = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_gen(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (gen_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // Leaves the bench in the last HOLD cycle (done high) on success.
    task automatic run_frame(output bit ok);
        bit ok_g, ok_d;
        wait_gen(ok_g);
        step(3);
        vsync_in = 1'b0;
        step(1);
        vsync_in = 1'b1;
        wait_done(ok_d);
        ok = ok_g & ok_d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        payload_req = 1'b0; confirm_req = 1'b0; vsync_in = 1'b1;
        payload_req_3 = 1'b0; confirm_req_3 = 1'b0; vsync_in_3 = 1'b1;
        #3;
        n_cmp++;
        if ({phy_rstn, gen_en, sel_confirm, busy, done, drop_cnt, dbg_state} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b",
                     {phy_rstn, gen_en, sel_confirm, busy, done, drop_cnt, dbg_state}, 15'h0);
        end
        n_cmp++;
        if ({phy_rstn_3, gen_en_3, sel_confirm_3, busy_3, done_3, drop_cnt_3, dbg_state_3} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs_3: got %b want %b",
                     {phy_rstn_3, gen_en_3, sel_confirm_3, busy_3, done_3, drop_cnt_3, dbg_state_3}, 15'h0);
        end
        step(2);
        rst_n = 1'b1;
        step(4);
        n_cmp++;
        if ({busy, phy_rstn, busy_3, phy_rstn_3} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b want %b", {busy, phy_rstn, busy_3, phy_rstn_3}, 4'b0000);
        end
    endtask

    task automatic test_single_payload;
        do_reset();
        payload_req = 1'b1;
        step(1);
        payload_req = 1'b0;
        n_cmp++;
        if ({busy, phy_rstn} !== 2'b01) begin
            n_err++;
            $display("FAIL single_grant_cycle: busy,phy_rstn got %b want %b", {busy, phy_rstn}, 2'b01);
        end
        step(1);
        n_cmp++;
        if ({busy, sel_confirm, gen_en, phy_rstn} !== 4'b1001) begin
            n_err++;
            $display("FAIL single_wake_entry: busy,sel,gen_en,phy_rstn got %b want %b",
                     {busy, sel_confirm, gen_en, phy_rstn}, 4'b1001);
        end
        step(15);
        n_cmp++;
        if (gen_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_gen_en_early: got %b want %b", gen_en, 1'b0);
        end
        step(1);
        n_cmp++;
        if (gen_en !== 1'b1) begin
            n_err++;
            $display("FAIL single_gen_en_rise: got %b want %b", gen_en, 1'b1);
        end
        step(99);
        vsync_in = 1'b0;
        n_cmp++;
        if (gen_en !== 1'b1) begin
            n_err++;
            $display("FAIL single_send_held: got %b want %b", gen_en, 1'b1);
        end
        step(1);
        vsync_in = 1'b1;
        n_cmp++;
        if ({gen_en, phy_rstn, done} !== 3'b010) begin
            n_err++;
            $display("FAIL single_hold_entry: gen_en,phy_rstn,done got %b want %b",
                     {gen_en, phy_rstn, done}, 3'b010);
        end
        step(6);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_early: got %b want %b", done, 1'b0);
        end
        step(1);
        n_cmp++;
        if ({done, phy_rstn, busy} !== 3'b111) begin
            n_err++;
            $display("FAIL single_done_pulse: done,phy_rstn,busy got %b want %b", {done, phy_rstn, busy}, 3'b111);
        end
        step(1);
        n_cmp++;
        if ({done, phy_rstn, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL single_back_idle: done,phy_rstn,busy got %b want %b", {done, phy_rstn, busy}, 3'b000);
        end
    endtask

    task automatic test_both_same_cycle;
        bit ok;
        int base;
        do_reset();
        base = done_pulses;
        payload_req = 1'b1; confirm_req = 1'b1;
        step(1);
        payload_req = 1'b0; confirm_req = 1'b0;
        step(1);
        n_cmp++;
        if ({busy, sel_confirm} !== 2'b11) begin
            n_err++;
            $display("FAIL both_first_confirm: busy,sel got %b want %b", {busy, sel_confirm}, 2'b11);
        end
        run_frame(ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL both_frame1_timeout: got %b want %b", ok, 1'b1);
        end
        step(1);
        n_cmp++;
        if ({busy, phy_rstn, sel_confirm} !== 3'b011) begin
            n_err++;
            $display("FAIL both_second_grant: busy,phy_rstn,sel got %b want %b", {busy, phy_rstn, sel_confirm}, 3'b011);
        end
        step(1);
        n_cmp++;
        if ({busy, sel_confirm} !== 2'b10) begin
            n_err++;
            $display("FAIL both_second_payload: busy,sel got %b want %b", {busy, sel_confirm}, 2'b10);
        end
        run_frame(ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL both_frame2_timeout: got %b want %b", ok, 1'b1);
        end
        step(11);
        n_cmp++;
        if ({busy, drop_cnt} !== 9'h000 || done_pulses - base !== 2) begin
            n_err++;
            $display("FAIL both_final: busy=%b drop_cnt=%0d done_pulses=%0d want busy=0 drop_cnt=0 done_pulses=2",
                     busy, drop_cnt, done_pulses - base);
        end
    endtask

    task automatic test_drops_in_send;
        bit ok;
        int base;
        do_reset();
        base = done_pulses;
        payload_req = 1'b1;
        step(1);
        payload_req = 1'b0;
        wait_gen(ok);
        repeat (3) begin
            payload_req = 1'b1;
            step(1);
            payload_req = 1'b0;
            step(2);
        end
        n_cmp++;
        if ({ok, gen_en, drop_cnt} !== {2'b11, 8'd2}) begin
            n_err++;
            $display("FAIL drops_count: ok=%b gen_en=%b drop_cnt=%0d want ok=1 gen_en=1 drop_cnt=2", ok, gen_en, drop_cnt);
        end
        vsync_in = 1'b0;
        step(1);
        vsync_in = 1'b1;
        wait_done(ok);
        step(1);
        n_cmp++;
        if ({ok, busy, phy_rstn, sel_confirm} !== 4'b1010) begin
            n_err++;
            $display("FAIL drops_extra_grant: ok,busy,phy_rstn,sel got %b want %b",
                     {ok, busy, phy_rstn, sel_confirm}, 4'b1010);
        end
        run_frame(ok);
        step(11);
        n_cmp++;
        if ({ok, busy, drop_cnt} !== {2'b10, 8'd2} || done_pulses - base !== 2) begin
            n_err++;
            $display("FAIL drops_one_extra: ok=%b busy=%b drop_cnt=%0d done_pulses=%0d want ok=1 busy=0 drop_cnt=2 done_pulses=2",
                     ok, busy, drop_cnt, done_pulses - base);
        end
    endtask

    task automatic test_frames3;
        do_reset();
        payload_req_3 = 1'b1;
        step(1);
        payload_req_3 = 1'b0;
        step(1);
        vsync_in_3 = 1'b0; step(1);
        vsync_in_3 = 1'b1; step(1);
        vsync_in_3 = 1'b0; step(1);
        vsync_in_3 = 1'b1;
        n_cmp++;
        if ({busy_3, gen_en_3} !== 2'b10) begin
            n_err++;
            $display("FAIL f3_wake_last: busy,gen_en got %b want %b", {busy_3, gen_en_3}, 2'b10);
        end
        step(1);
        vsync_in_3 = 1'b0;
        n_cmp++;
        if (gen_en_3 !== 1'b1) begin
            n_err++;
            $display("FAIL f3_send_entry: got %b want %b", gen_en_3, 1'b1);
        end
        step(1);
        vsync_in_3 = 1'b1;
        step(4);
        vsync_in_3 = 1'b0;
        step(1);
        vsync_in_3 = 1'b1;
        n_cmp++;
        if (gen_en_3 !== 1'b1) begin
            n_err++;
            $display("FAIL f3_after_two_edges: got %b want %b", gen_en_3, 1'b1);
        end
        step(3);
        vsync_in_3 = 1'b0;
        step(1);
        n_cmp++;
        if ({gen_en_3, busy_3, phy_rstn_3, dbg_state_3} !== 5'b01111) begin
            n_err++;
            $display("FAIL f3_hold_entry: gen_en,busy,phy_rstn,state got %b want %b",
                     {gen_en_3, busy_3, phy_rstn_3, dbg_state_3}, 5'b01111);
        end
        vsync_in_3 = 1'b1; step(1);
        vsync_in_3 = 1'b0; step(1);
        n_cmp++;
        if (done_3 !== 1'b0) begin
            n_err++;
            $display("FAIL f3_done_early: got %b want %b", done_3, 1'b0);
        end
        vsync_in_3 = 1'b1; step(1);
        n_cmp++;
        if (done_3 !== 1'b1) begin
            n_err++;
            $display("FAIL f3_done_pulse: got %b want %b", done_3, 1'b1);
        end
        vsync_in_3 = 1'b0; step(1);
        vsync_in_3 = 1'b1; step(1);
        vsync_in_3 = 1'b0; step(1);
        n_cmp++;
        if ({busy_3, done_3, phy_rstn_3} !== 3'b000) begin
            n_err++;
            $display("FAIL f3_idle_after: busy,done,phy_rstn got %b want %b", {busy_3, done_3, phy_rstn_3}, 3'b000);
        end
        vsync_in_3 = 1'b1;
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        bit seen_activity;
        int base;
        do_reset();
        payload_req = 1'b1;
        step(1);
        payload_req = 1'b0;
        wait_gen(ok);
        confirm_req = 1'b1;
        step(1);
        confirm_req = 1'b0;
        step(5);
        base = done_pulses;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ok, phy_rstn, gen_en, sel_confirm, busy, done, drop_cnt} !== {1'b1, 13'h0}) begin
            n_err++;
            $display("FAIL midsend_reset_outputs: got %b want %b",
                     {ok, phy_rstn, gen_en, sel_confirm, busy, done, drop_cnt}, {1'b1, 13'h0});
        end
        step(2);
        rst_n = 1'b1;
        seen_activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vsync_in = i[0];
            step(1);
            if (busy !== 1'b0 || phy_rstn !== 1'b0) seen_activity = 1'b1;
        end
        vsync_in = 1'b1;
        n_cmp++;
        if (seen_activity !== 1'b0 || done_pulses !== base) begin
            n_err++;
            $display("FAIL midsend_no_frame_after: activity=%b done_pulses=%0d want activity=0 done_pulses=%0d",
                     seen_activity, done_pulses, base);
        end
    endtask

    task automatic test_drop_saturate;
        do_reset();
        payload_req = 1'b1;
        step(1);
        step(1);
        payload_req = 1'b0;
        n_cmp++;
        if ({busy, drop_cnt} !== {1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL sat_grant_cycle_req: busy=%b drop_cnt=%0d want busy=1 drop_cnt=0", busy, drop_cnt);
        end
        payload_req = 1'b1; step(1); payload_req = 1'b0; step(1);
        n_cmp++;
        if (drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL sat_first_drop: got %0d want %0d", drop_cnt, 1);
        end
        repeat (253) begin
            payload_req = 1'b1; step(1); payload_req = 1'b0; step(1);
        end
        n_cmp++;
        if (drop_cnt !== 8'd254) begin
            n_err++;
            $display("FAIL sat_254: got %0d want %0d", drop_cnt, 254);
        end
        repeat (46) begin
            payload_req = 1'b1; step(1); payload_req = 1'b0; step(1);
        end
        n_cmp++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_300: got %0d want %0d", drop_cnt, 255);
        end
    endtask

    initial begin
        test_reset();
        test_single_payload();
        test_both_same_cycle();
        test_drops_in_send();
        test_frames3();
        test_reset_mid_send();
        test_drop_saturate();
        rst_n = 1'b0;
        step(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
